// File: rtl/sequenciador_ula_banco.sv
// Multi-cycle register-to-register sequencer: reads two operands from the
// 16x16 register bank, runs a 16-bit ALU operation and writes the result back.
module sequenciador_ula_banco #(
  parameter int LARGURA  = 16,
  parameter int BITS_END = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inicio,
  input  logic [3:0]          opcode,
  input  logic [BITS_END-1:0] end_dest,
  input  logic [BITS_END-1:0] end_fonte,
  output logic                ocupado,
  output logic                pronto,
  output logic                erro,
  output logic [3:0]          flags,
  output logic                hab_escrita,
  output logic [BITS_END-1:0] end_a,
  output logic [BITS_END-1:0] end_b,
  input  logic [LARGURA-1:0]  dado_a,
  input  logic [LARGURA-1:0]  dado_b,
  output logic [LARGURA-1:0]  dado_e
);

  localparam int MSB = LARGURA - 1;
  localparam logic [LARGURA-1:0] UM = {{(LARGURA-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;

  typedef enum logic [2:0] {
    OCIOSO,
    LEITURA,
    EXECUTA,
    ESCRITA,
    FIM
  } estado_t;

  estado_t                estado, prox_estado;
  logic [3:0]             op_q;
  logic [BITS_END-1:0]    dest_q, fonte_q;
  logic [LARGURA-1:0]     resultado;
  logic [3:0]             flags_q;

  logic [LARGURA-1:0]     operando_b;
  logic [LARGURA:0]       soma, dif;
  logic [LARGURA-1:0]     res_c;
  logic                   c_c, v_c;
  logic                   ilegal, escreve;

  assign ilegal  = (op_q > OP_DEC);
  assign escreve = !ilegal && (op_q != OP_CMP);

  // INC/DEC reuse the add/subtract paths with a constant second operand.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    operando_b = ((op_q == OP_INC) || (op_q == OP_DEC)) ? UM : dado_b;
    soma       = {1'b0, dado_a} + {1'b0, operando_b};
    dif        = {1'b0, dado_a} - {1'b0, operando_b};
    res_c      = '0;
    c_c        = 1'b0;
    v_c        = 1'b0;
    case (op_q)
      OP_ADD, OP_INC: begin
        res_c = soma[MSB:0];
        c_c   = soma[LARGURA];
        v_c   = (dado_a[MSB] == operando_b[MSB]) && (soma[MSB] != dado_a[MSB]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        res_c = dif[MSB:0];
        c_c   = dif[LARGURA];
        v_c   = (dado_a[MSB] != operando_b[MSB]) && (dif[MSB] != dado_a[MSB]);
      end
      OP_AND: res_c = dado_a & dado_b;
      OP_OR:  res_c = dado_a | dado_b;
      OP_XOR: res_c = dado_a ^ dado_b;
      OP_NOT: res_c = ~dado_a;
      OP_SHL: begin
        res_c = {dado_a[MSB-1:0], 1'b0};
        c_c   = dado_a[MSB];
      end
      OP_SHR: begin
        res_c = {1'b0, dado_a[MSB:1]};
        c_c   = dado_a[0];
      end
      OP_MOV: res_c = dado_b;
      default: ;
    endcase
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (inicio) prox_estado = LEITURA;
      LEITURA: prox_estado = EXECUTA;
      EXECUTA: prox_estado = escreve ? ESCRITA : FIM;
      ESCRITA: prox_estado = FIM;
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      estado    <= OCIOSO;
      op_q      <= '0;
      dest_q    <= '0;
      fonte_q   <= '0;
      resultado <= '0;
      flags_q   <= '0;
    end else begin
      estado <= prox_estado;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            op_q    <= opcode;
            dest_q  <= end_dest;
            fonte_q <= end_fonte;
          end
        end
        EXECUTA: begin
          resultado <= res_c;
          // Illegal opcodes leave the status untouched.
          if (!ilegal) flags_q <= {(res_c == '0), res_c[MSB], c_c, v_c};
        end
        default: ;
      endcase
    end
  end

  // The latched addresses are stable from LEITURA through ESCRITA, so the
  // bank ports are driven straight from them and hold between commands.
  assign end_a       = dest_q;
  assign end_b       = fonte_q;
  assign dado_e      = resultado;
  assign flags       = flags_q;
  assign ocupado     = (estado == LEITURA) || (estado == EXECUTA) || (estado == ESCRITA);
  assign pronto      = (estado == FIM);
  assign erro        = (estado == FIM) && ilegal;
  assign hab_escrita = (estado == ESCRITA);

endmodule

// File: tb/tb_sequenciador_ula_banco.sv
// Self-checking bench: a behavioural bank plus an arithmetic reference model
// compared against the sequencer for directed and random commands.
module tb_sequenciador_ula_banco;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicio;
  logic [3:0]  opcode;
  logic [3:0]  end_dest;
  logic [3:0]  end_fonte;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [3:0]  flags;
  logic        hab_escrita;
  logic [3:0]  end_a;
  logic [3:0]  end_b;
  logic [15:0] dado_a;
  logic [15:0] dado_b;
  logic [15:0] dado_e;

  logic [15:0] bank [16] = '{default: 16'h0000};
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  exp_flags;

  sequenciador_ula_banco #(.LARGURA(16), .BITS_END(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .inicio      (inicio),
    .opcode      (opcode),
    .end_dest    (end_dest),
    .end_fonte   (end_fonte),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .erro        (erro),
    .flags       (flags),
    .hab_escrita (hab_escrita),
    .end_a       (end_a),
    .end_b       (end_b),
    .dado_a      (dado_a),
    .dado_b      (dado_b),
    .dado_e      (dado_e)
  );

  always #5 clock = ~clock;

  // Register bank: synchronous read, one write port shared with the preload path.
  always @(posedge clock) begin
    dado_a <= bank[end_a];
    dado_b <= bank[end_b];
    if (hab_escrita) bank[end_a] <= dado_e;
    if (pl_en) bank[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic carrega(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void modelo(input logic [3:0] op, input int unsigned a, input int unsigned b,
                                 input logic [3:0] flags_in, output int unsigned res,
                                 output logic [3:0] fl, output bit wr, output bit ill);
    int sa, sb, s;
    bit c, v;
    sa  = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb  = (b >= 32768) ? int'(b) - 65536 : int'(b);
    ill = (op >= 12);
    wr  = !ill && (op != 9);
    c = 0; v = 0; s = 0; res = 0;
    case (op)
      0:    begin res = (a + b) % 65536; c = (a + b) > 65535; s = sa + sb; end
      1, 9: begin res = (a + 65536 - b) % 65536; c = a < b; s = sa - sb; end
      2:    res = a & b;
      3:    res = a | b;
      4:    res = a ^ b;
      5:    res = 65535 - a;
      6:    begin res = (a * 2) % 65536; c = a >= 32768; end
      7:    begin res = a / 2; c = (a % 2) == 1; end
      8:    res = b;
      10:   begin res = (a + 1) % 65536; c = (a == 65535); s = sa + 1; end
      11:   begin res = (a + 65535) % 65536; c = (a == 0); s = sa - 1; end
      default: ;
    endcase
    if (op <= 1 || op == 9 || op == 10 || op == 11) v = (s > 32767) || (s < -32768);
    fl = ill ? flags_in : {res == 0, res >= 32768, c, v};
  endfunction

  // Issues one command and watches 8 cycles; poke_sel re-pulses inicio while
  // the command is in flight (1: LEITURA, 2: EXECUTA, 3: cycle of pronto).
  task automatic executa_cmd(input logic [3:0] op, input logic [3:0] d, input logic [3:0] f,
                             input int poke_sel);
    int unsigned res;
    logic [3:0]  fl, fl_obs, wa;
    logic [15:0] wd;
    bit          wr, ill, ocup_ok;
    int          lat, poke, n_pr, n_wr, n_er, pr_k, wr_k, er_k;
    modelo(op, bank[d], bank[f], exp_flags, res, fl, wr, ill);
    lat  = wr ? 4 : 3;
    poke = (poke_sel == 3) ? lat : poke_sel;
    @(negedge clock);
    opcode = op; end_dest = d; end_fonte = f; inicio = 1'b1;
    n_pr = 0; n_wr = 0; n_er = 0; pr_k = -1; wr_k = -1; er_k = -1;
    ocup_ok = 1; wa = 0; wd = 0; fl_obs = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      inicio = (k == poke);
      if (k == poke) begin
        opcode = 4'($urandom); end_dest = 4'($urandom); end_fonte = 4'($urandom);
      end
      if (hab_escrita) begin n_wr++; wr_k = k; wa = end_a; wd = dado_e; end
      if (pronto) begin n_pr++; pr_k = k; fl_obs = flags; end
      if (erro) begin n_er++; er_k = k; end
      if (ocupado !== (k < lat)) ocup_ok = 0;
    end
    check("pronto_count", n_pr, 1);
    check("pronto_cycle", pr_k, lat);
    check("write_count", n_wr, wr ? 1 : 0);
    if (wr) begin
      check("write_cycle", wr_k, 3);
      check("write_addr", wa, d);
      check("write_data", wd, res);
      check("bank_dest", bank[d], res);
    end
    check("erro_cycle", er_k, ill ? lat : -1);
    check("erro_count", n_er, ill ? 1 : 0);
    check("flags", fl_obs, fl);
    check("ocupado_window", ocup_ok, 1);
    exp_flags = fl;
  endtask

  initial begin : main
    logic [15:0] antes;
    int nw, np;
    reset = 1'b1; inicio = 1'b0; opcode = '0; end_dest = '0; end_fonte = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    exp_flags = 4'b0000;
    repeat (2) @(negedge clock);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_erro", erro, 0);
    check("rst_hab_escrita", hab_escrita, 0);
    check("rst_ports", {end_a, end_b, dado_e, flags}, 0);
    reset = 1'b0;

    carrega(3, 16'h0005); carrega(8, 16'h0003);
    executa_cmd(0, 3, 8, 0);
    check("add_plain_flags", exp_flags, 4'b0000);
    carrega(1, 16'h7FFF); carrega(2, 16'h0001);
    executa_cmd(0, 1, 2, 0);
    check("add_ovf_flags", exp_flags, 4'b0101);
    carrega(4, 16'h0002); carrega(5, 16'h0002);
    executa_cmd(9, 4, 5, 2);
    check("cmp_eq_flags", exp_flags, 4'b1000);
    carrega(6, 16'h0000);
    executa_cmd(11, 6, 0, 0);
    check("dec_zero_bank", bank[6], 16'hFFFF);
    executa_cmd(13, 2, 7, 3);
    check("illegal_flags_kept", flags, 4'b0110);

    // Reset while in LEITURA aborts the SUB: no write, no pronto.
    antes = bank[3];
    @(negedge clock);
    opcode = 4'd1; end_dest = 4'd3; end_fonte = 4'd8; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    check("abort_ocupado_before", ocupado, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ocupado_after", ocupado, 0);
    check("abort_regs", {end_a, flags}, 0);
    nw = 0; np = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (hab_escrita) nw++;
      if (pronto) np++;
    end
    check("abort_no_write", nw, 0);
    check("abort_no_pronto", np, 0);
    check("abort_bank_kept", bank[3], antes);
    exp_flags = 4'b0000;

    // Reset coinciding with ESCRITA: the write lands, flags are cleared.
    carrega(7, 16'h0001); carrega(9, 16'h0002);
    @(negedge clock);
    opcode = 4'd1; end_dest = 4'd7; end_fonte = 4'd9; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    repeat (2) @(negedge clock);
    check("escrita_rst_we", hab_escrita, 1);
    check("escrita_rst_flags_pre", flags, 4'b0110);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("escrita_rst_bank", bank[7], 16'hFFFF);
    check("escrita_rst_flags", flags, 0);
    check("escrita_rst_idle", {ocupado, pronto}, 0);
    exp_flags = 4'b0000;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0: carrega(4'($urandom), 16'h0000);
          1: carrega(4'($urandom), 16'h7FFF);
          2: carrega(4'($urandom), 16'h8000);
          3: carrega(4'($urandom), 16'hFFFF);
          default: carrega(4'($urandom), 16'($urandom));
        endcase
      end
      executa_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
